// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB and drives ALU, mux and write-enable controls.
// Optional build macro CTRL_INSTR_COUNT_EN adds a retired-instruction counter output (instr_count).
module multi_cycle_ctrl #(
    parameter int OPW = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic [2:0]     state,
    output logic           PCWre,
    output logic           IRWre,
    output logic           RegWre,
    output logic           mRD,
    output logic           mWR,
    output logic [2:0]     ALUOp,
    output logic           ALUSrcB,
    output logic           ExtSel,
    output logic           RegDst,
    output logic           DBDataSrc,
    output logic [1:0]     PCSrc
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [31:0]    instr_count
`endif
);

    localparam logic [2:0] ST_IF    = 3'b000;
    localparam logic [2:0] ST_ID    = 3'b001;
    localparam logic [2:0] ST_EXE_M = 3'b010;
    localparam logic [2:0] ST_MEM   = 3'b011;
    localparam logic [2:0] ST_WB_L  = 3'b100;
    localparam logic [2:0] ST_EXE_B = 3'b101;
    localparam logic [2:0] ST_EXE_R = 3'b110;
    localparam logic [2:0] ST_WB_R  = 3'b111;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6'b010011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b110;

    logic [2:0] state_reg;
    logic [2:0] state_next;

    // Opcode decode (the IR holds opcode stable for the whole instruction)
    logic       is_add, is_sub, is_addi, is_or, is_and, is_ori, is_xor;
    logic       is_sw, is_lw, is_beq, is_j, is_halt;
    logic       is_alu_instr;
    logic       is_mem_instr;
    logic [2:0] alu_r_op;

    always_comb begin
        is_add  = (opcode == OP_ADD);
        is_sub  = (opcode == OP_SUB);
        is_addi = (opcode == OP_ADDI);
        is_or   = (opcode == OP_OR);
        is_and  = (opcode == OP_AND);
        is_ori  = (opcode == OP_ORI);
        is_xor  = (opcode == OP_XOR);
        is_sw   = (opcode == OP_SW);
        is_lw   = (opcode == OP_LW);
        is_beq  = (opcode == OP_BEQ);
        is_j    = (opcode == OP_J);
        is_halt = (opcode == OP_HALT);

        is_alu_instr = is_add | is_sub | is_addi | is_or | is_and | is_ori | is_xor;
        is_mem_instr = is_lw | is_sw;

        alu_r_op = ALU_ADD;
        if (is_sub) begin
            alu_r_op = ALU_SUB;
        end else if (is_or || is_ori) begin
            alu_r_op = ALU_OR;
        end else if (is_and) begin
            alu_r_op = ALU_AND;
        end else if (is_xor) begin
            alu_r_op = ALU_XOR;
        end
    end

    // Next-state logic; unknown opcodes fall through ID back to IF as a NOP
    always_comb begin
        state_next = ST_IF;
        case (state_reg)
            ST_IF: state_next = ST_ID;
            ST_ID: begin
                if (is_halt) begin
                    state_next = ST_ID;
                end else if (is_alu_instr) begin
                    state_next = ST_EXE_R;
                end else if (is_mem_instr) begin
                    state_next = ST_EXE_M;
                end else if (is_beq) begin
                    state_next = ST_EXE_B;
                end else begin
                    state_next = ST_IF;
                end
            end
            ST_EXE_R: state_next = ST_WB_R;
            ST_WB_R:  state_next = ST_IF;
            ST_EXE_M: state_next = ST_MEM;
            ST_MEM:   state_next = is_lw ? ST_WB_L : ST_IF;
            ST_WB_L:  state_next = ST_IF;
            ST_EXE_B: state_next = ST_IF;
            default:  state_next = ST_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IF;
        end else begin
            state_reg <= state_next;
        end
    end

    // Raw controls before the reset gate
    logic       pcwre_raw, irwre_raw, regwre_raw, mrd_raw, mwr_raw;
    logic [2:0] aluop_raw;
    logic       alusrcb_raw, extsel_raw, regdst_raw, dbdatasrc_raw;
    logic [1:0] pcsrc_raw;

    always_comb begin
        pcwre_raw     = 1'b0;
        irwre_raw     = (state_reg == ST_IF);
        regwre_raw    = (state_reg == ST_WB_R) || (state_reg == ST_WB_L);
        mrd_raw       = (state_reg == ST_MEM) && is_lw;
        mwr_raw       = (state_reg == ST_MEM) && is_sw;
        dbdatasrc_raw = (state_reg == ST_WB_L);
        aluop_raw     = ALU_ADD;
        pcsrc_raw     = 2'b00;

        alusrcb_raw   = is_addi | is_ori | is_lw | is_sw;
        extsel_raw    = ~is_ori;
        regdst_raw    = is_add | is_sub | is_or | is_and | is_xor;

        case (state_reg)
            ST_ID: begin
                // j and NOP retire here; halt never advances the PC
                pcwre_raw = ~(is_halt | is_alu_instr | is_mem_instr | is_beq);
                if (is_j) begin
                    pcsrc_raw = 2'b10;
                end
            end
            ST_EXE_R: aluop_raw = alu_r_op;
            ST_WB_R: begin
                aluop_raw = alu_r_op;
                pcwre_raw = 1'b1;
            end
            ST_EXE_M: aluop_raw = ALU_ADD;
            ST_MEM:   pcwre_raw = is_sw;
            ST_WB_L:  pcwre_raw = 1'b1;
            ST_EXE_B: begin
                aluop_raw = ALU_SUB;
                pcwre_raw = 1'b1;
                pcsrc_raw = zero ? 2'b01 : 2'b00;
            end
            default: begin
                aluop_raw = ALU_ADD;
            end
        endcase
    end

    // Reset forces every output low in the same cycle so an aborted instruction writes nothing
    always_comb begin
        state     = RST ? 3'b000 : state_reg;
        PCWre     = ~RST & pcwre_raw;
        IRWre     = ~RST & irwre_raw;
        RegWre    = ~RST & regwre_raw;
        mRD       = ~RST & mrd_raw;
        mWR       = ~RST & mwr_raw;
        ALUOp     = RST ? 3'b000 : aluop_raw;
        ALUSrcB   = ~RST & alusrcb_raw;
        ExtSel    = ~RST & extsel_raw;
        RegDst    = ~RST & regdst_raw;
        DBDataSrc = ~RST & dbdatasrc_raw;
        PCSrc     = RST ? 2'b00 : pcsrc_raw;
    end

`ifdef CTRL_INSTR_COUNT_EN
    logic [31:0] instr_count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_count_reg <= 32'd0;
        end else if (PCWre) begin
            instr_count_reg <= instr_count_reg + 32'd1;
        end
    end

    assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: driver pushes expected per-cycle controls, monitor pops and compares.
module tb_multi_cycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] state;
    logic       PCWre, IRWre, RegWre, mRD, mWR;
    logic [2:0] ALUOp;
    logic       ALUSrcB, ExtSel, RegDst, DBDataSrc;
    logic [1:0] PCSrc;
`ifdef CTRL_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    multi_cycle_ctrl #(.OPW(6)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .RegDst(RegDst), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
`ifdef CTRL_INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 CLK = ~CLK;

    localparam logic [2:0] IF_ = 3'b000, ID_ = 3'b001, EXM = 3'b010, MEM = 3'b011,
                           WBL = 3'b100, EXB = 3'b101, EXR = 3'b110, WBR = 3'b111;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR_ = 6'b010000,
                           AND_ = 6'b010001, ORI = 6'b010010, XOR_ = 6'b010011, SW = 6'b110000,
                           LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000, HALT = 6'b111111;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, regwre, mrd, mwr;
        logic [2:0] aluop;
        logic       alusrcb, extsel, regdst, dbdatasrc;
        logic [1:0] pcsrc;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic [31:0] cnt;
        bit          cnt_chk;
    } exp_t;

    typedef logic [2:0] stq_t[$];

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cnt_model = 32'd0;
    bit          cnt_known = 1'b0;

    // ---------------- reference model ----------------
    function automatic bit is_r(input logic [5:0] op);
        return op inside {ADD, SUB, ADDI, OR_, AND_, ORI, XOR_};
    endfunction

    // Sequence of states an instruction walks through (halt handled by caller)
    function automatic stq_t path(input logic [5:0] op);
        stq_t p;
        p = {IF_, ID_};
        if (is_r(op))        p = {p, EXR, WBR};
        else if (op == LW)   p = {p, EXM, MEM, WBL};
        else if (op == SW)   p = {p, EXM, MEM};
        else if (op == BEQ)  p = {p, EXB};
        return p;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            SUB, BEQ:  return 3'b001;
            OR_, ORI:  return 3'b011;
            AND_:      return 3'b100;
            XOR_:      return 3'b110;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic outs_t expect_step(input logic [5:0] op, input logic [2:0] st,
                                          input bit last, input logic z);
        outs_t e;
        e = '0;
        e.st        = st;
        e.irwre     = (st == IF_);
        e.pcwre     = last;
        e.regwre    = (st == WBR) || (st == WBL);
        e.dbdatasrc = (st == WBL);
        e.mrd       = (st == MEM) && (op == LW);
        e.mwr       = (st == MEM) && (op == SW);
        e.alusrcb   = op inside {ADDI, ORI, LW, SW};
        e.extsel    = (op != ORI);
        e.regdst    = op inside {ADD, SUB, OR_, AND_, XOR_};
        e.aluop     = (st inside {EXR, WBR, EXM, EXB}) ? alu_of(op) : 3'b000;
        if (st == ID_ && op == J)       e.pcsrc = 2'b10;
        else if (st == EXB && z)        e.pcsrc = 2'b01;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic rst, input logic [5:0] op, input logic z, input outs_t e);
        exp_t x;
        @(posedge CLK);
        #1;
        RST = rst; opcode = op; zero = z;
        x.o = e; x.cnt = cnt_model; x.cnt_chk = cnt_known;
        sb.push_back(x);
    endtask

    task automatic reset_cycle(input logic [5:0] op);
        drive_cycle(1'b1, op, 1'($urandom_range(1)), '0);
        cnt_model = 32'd0;
        cnt_known = 1'b1;
    endtask

    // zsel: 0/1 forces zero, 2 randomises it; abort_at: step index where RST is raised (-1 none)
    task automatic run_instr(input logic [5:0] op, input int zsel, input int abort_at, input int halt_cycles);
        stq_t p;
        logic z;
        bit   halt;
        halt = (op == HALT);
        if (halt) begin
            p = {IF_};
            for (int i = 0; i < halt_cycles; i++) p.push_back(ID_);
        end else begin
            p = path(op);
        end
        $display("txn op=%b steps=%0d abort_at=%0d", op, p.size(), abort_at);
        for (int i = 0; i < p.size(); i++) begin
            z = (zsel == 2) ? 1'($urandom_range(1)) : 1'(zsel);
            if (i == abort_at) begin
                reset_cycle(op);
                return;
            end
            drive_cycle(1'b0, op, z, expect_step(op, p[i], !halt && (i == p.size() - 1), z));
        end
        if (halt) reset_cycle(op);
        else cnt_model = cnt_model + 32'd1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t  x;
        outs_t act;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                act = '{state, PCWre, IRWre, RegWre, mRD, mWR, ALUOp,
                        ALUSrcB, ExtSel, RegDst, DBDataSrc, PCSrc};
                n_checks++;
                if (act !== x.o) begin
                    n_fail++;
                    $display("FAIL ctrl t=%0t op=%b zero=%b rst=%b actual=%h required=%h",
                             $time, opcode, zero, RST, act, x.o);
                end
`ifdef CTRL_INSTR_COUNT_EN
                if (x.cnt_chk) begin
                    n_checks++;
                    if (instr_count !== x.cnt) begin
                        n_fail++;
                        $display("FAIL instr_count t=%0t actual=%0d required=%0d",
                                 $time, instr_count, x.cnt);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    localparam int NOPS = 12;
    logic [5:0] ops [NOPS] = '{ADD, SUB, ADDI, OR_, AND_, ORI, XOR_, SW, LW, BEQ, J, HALT};

    initial begin
        logic [5:0] op;
        int         ab;
        stq_t       p;

        reset_cycle(ADD);
        reset_cycle(ADD);

        // directed sequence
        run_instr(ADD, 2, -1, 0);
        run_instr(LW, 2, -1, 0);
        run_instr(SW, 2, -1, 0);
        run_instr(BEQ, 1, -1, 0);
        run_instr(BEQ, 0, -1, 0);
        run_instr(J, 2, -1, 0);
        run_instr(ORI, 2, -1, 0);
        run_instr(6'b000111, 2, -1, 0);
        run_instr(HALT, 2, -1, 20);
        run_instr(SW, 2, 3, 0);
        run_instr(LW, 2, 4, 0);
        run_instr(XOR_, 2, -1, 0);

        // randomised sequence
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) op = 6'($urandom_range(63));
            else op = ops[$urandom_range(NOPS - 1)];
            p = path(op);
            ab = ($urandom_range(9) == 0) ? int'($urandom_range(p.size() - 1)) : -1;
            run_instr(op, 2, (op == HALT) ? -1 : ab, int'($urandom_range(6, 1)));
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle control unit for the 32-bit CPU, directly upstream of the 3-bit-op ALU.
- Sequences each instruction through IF/ID/EXE/MEM/WB states.
- Drives ALU op select, operand select and every write enable; consumes the ALU zero flag for beq.
- Opcode comes from the instruction register, which holds it stable for the whole instruction.

Parameters:
- OPW, 6, opcode width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- opcode  in  OPW  instruction[31:26] from IR.
- zero  in  1  ALU zero flag (result == 0).
- state  out  3  current state, for debug.
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR write enable.
- RegWre  out  1  register file write enable.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- ALUOp  out  3  ALU op: 000 A+B, 001 A-B, 010 B-A, 011 A|B, 100 A&B, 101 ~A&B, 110 A^B, 111 ~(A^B).
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- RegDst  out  1  1 = rd, 0 = rt.
- DBDataSrc  out  1  1 = memory data, 0 = ALU result.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target.

Behaviour:
- One clock, CLK. RST synchronous active-high; sampled on the CLK rising edge.
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, xor 010011, sw 110000, lw 110001, beq 110100, j 111000, halt 111111. Any other opcode is a NOP.
- State encoding: IF 000, ID 001, EXE_M 010, MEM 011, WB_L 100, EXE_B 101, EXE_R 110, WB_R 111.
- Transitions:
  - IF -> ID.
  - ID -> EXE_R (add/sub/addi/or/and/ori/xor), EXE_M (lw/sw), EXE_B (beq), IF (j, NOP).
  - ID -> ID for halt: stays until reset.
  - EXE_R -> WB_R -> IF.
  - EXE_M -> MEM.
  - MEM -> WB_L (lw) or IF (sw).
  - WB_L -> IF.
  - EXE_B -> IF.
- Outputs are combinational from the state register and opcode; no output register.
- IRWre = 1 only in IF.
- PCWre = 1 for exactly one cycle per instruction, in its final state: ID (j, NOP), EXE_B, MEM (sw), WB_R, WB_L. Never asserted for halt.
- PCSrc:
  - 10 in ID for j.
  - 01 in EXE_B when zero = 1; 00 in EXE_B when zero = 0 (zero sampled in the same cycle).
  - 00 everywhere else.
- ALUOp:
  - EXE_R: add/addi 000, sub 001, or/ori 011, and 100, xor 110.
  - EXE_M: 000. EXE_B: 001.
  - WB_R: held at the EXE_R value so the ALU result stays stable.
  - All other states: 000.
- ALUSrcB = 1 for addi/ori/lw/sw; 0 otherwise.
- ExtSel = 0 for ori only; 1 otherwise.
- RegDst = 1 for add/sub/or/and/xor; 0 otherwise.
- mRD = 1 in MEM for lw. mWR = 1 in MEM for sw.
- RegWre = 1 in WB_R and WB_L only. DBDataSrc = 1 in WB_L only.
- Reset:
  - While RST is high: next state = IF, and PCWre, IRWre, RegWre, mRD, mWR are forced to 0. All other outputs are 0.
  - Reset asserted mid-instruction aborts it: no write enable in that cycle; IF on the first cycle after RST falls.
- Opcode changing outside IF is ignored for sequencing; decode uses the live opcode value, which the IR keeps stable.

Optional Feature:
- Macro: CTRL_INSTR_COUNT_EN.
- When defined:
  - Adds output instr_count [31:0], cleared by RST.
  - Increments by 1 on each rising edge where PCWre = 1 and RST = 0.
  - Wraps from FFFFFFFF to 0.
  - Halt does not count.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- RST=1 for 2 cycles, then opcode=000000 (add) -> states IF, ID, EXE_R, WB_R, IF. ALUOp=000 in EXE_R and WB_R. RegWre=1, RegDst=1, PCWre=1 only in WB_R.
- lw (110001) -> IF, ID, EXE_M, MEM, WB_L. ALUSrcB=1, ALUOp=000, mRD=1 in MEM, DBDataSrc=1 and RegWre=1 in WB_L. sw (110000) -> mWR=1 and PCWre=1 in MEM, then IF.
- beq (110100), zero=1 in EXE_B -> PCSrc=01, PCWre=1, ALUOp=001. Repeat with zero=0 -> PCSrc=00.
- j (111000) -> IF, ID, IF with PCSrc=10 and PCWre=1 in ID. ori (010010) -> ExtSel=0, ALUSrcB=1, ALUOp=011, RegDst=0.
- halt (111111) -> state stays 001 for 20 cycles, PCWre=0. RST pulse -> IF next cycle. RST asserted in MEM of sw -> mWR=0 that cycle.
- With CTRL_INSTR_COUNT_EN: run add, lw, beq, j, halt -> instr_count=4. RST -> 0.
